// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (I) and data access (D).
// D has priority; a grant streak counter and a timeout guarantee progress.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_width,
    input  logic        d_ext,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_width,
    output logic        m_ext,
    input  logic        m_ack,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic          owner_q, owner_n;
    logic [TW-1:0] timer_q, timer_n;
    logic [SW-1:0] streak_q, streak_n;

    logic        i_gnt_n, d_gnt_n, i_rvalid_n, d_rvalid_n;
    logic        i_err_n, d_err_n, m_req_n, m_we_n, m_ext_n;
    logic [31:0] i_rdata_n, d_rdata_n, m_addr_n, m_wdata_n;
    logic [1:0]  m_width_n;

    logic        grant_i, grant_d, complete, expire;
    logic [31:0] rd;

    // I wins only when it has waited out STARVE_LIMIT consecutive D grants
    assign grant_i  = i_req & (~d_req | (streak_q == SLIM));
    assign grant_d  = d_req & ~grant_i;
    assign complete = (state_q == WAIT) & m_rvalid;
    assign expire   = (state_q != IDLE) & (timer_q == TLAST) & ~complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            timer_q  <= '0;
            streak_q <= '0;
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_err    <= 1'b0;
            d_err    <= 1'b0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_width  <= '0;
            m_ext    <= 1'b0;
        end else begin
            state_q  <= state_n;
            owner_q  <= owner_n;
            timer_q  <= timer_n;
            streak_q <= streak_n;
            i_gnt    <= i_gnt_n;
            d_gnt    <= d_gnt_n;
            i_rvalid <= i_rvalid_n;
            d_rvalid <= d_rvalid_n;
            i_rdata  <= i_rdata_n;
            d_rdata  <= d_rdata_n;
            i_err    <= i_err_n;
            d_err    <= d_err_n;
            m_req    <= m_req_n;
            m_we     <= m_we_n;
            m_addr   <= m_addr_n;
            m_wdata  <= m_wdata_n;
            m_width  <= m_width_n;
            m_ext    <= m_ext_n;
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    if (grant_i | grant_d) state_n = ISSUE;
            ISSUE: begin
                if (expire)     state_n = IDLE;
                else if (m_ack) state_n = WAIT;
            end
            WAIT:    if (complete | expire) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        i_gnt_n    = 1'b0;
        d_gnt_n    = 1'b0;
        i_rvalid_n = 1'b0;
        d_rvalid_n = 1'b0;
        i_rdata_n  = '0;
        d_rdata_n  = '0;
        i_err_n    = 1'b0;
        d_err_n    = 1'b0;
        m_req_n    = m_req;
        m_we_n     = m_we;
        m_addr_n   = m_addr;
        m_wdata_n  = m_wdata;
        m_width_n  = m_width;
        m_ext_n    = m_ext;
        owner_n    = owner_q;
        timer_n    = timer_q;
        streak_n   = streak_q;
        rd         = m_we ? 32'h0 : m_rdata;
        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    owner_n   = 1'b0;
                    i_gnt_n   = 1'b1;
                    m_req_n   = 1'b1;
                    m_we_n    = 1'b0;
                    m_addr_n  = i_addr;
                    m_wdata_n = '0;
                    m_width_n = 2'b10;
                    m_ext_n   = 1'b0;
                    timer_n   = '0;
                    streak_n  = '0;
                end else if (grant_d) begin
                    owner_n   = 1'b1;
                    d_gnt_n   = 1'b1;
                    m_req_n   = 1'b1;
                    m_we_n    = d_we;
                    m_addr_n  = d_addr;
                    m_wdata_n = d_wdata;
                    m_width_n = d_width;
                    m_ext_n   = d_ext;
                    timer_n   = '0;
                    if (!i_req)
                        streak_n = '0;
                    else if (streak_q != SLIM)
                        streak_n = streak_q + 1'b1;
                end
            end
            ISSUE, WAIT: begin
                timer_n = timer_q + 1'b1;
                if ((state_q == ISSUE) && m_ack)
                    m_req_n = 1'b0;
                if (complete | expire) begin
                    m_req_n    = 1'b0;
                    d_rvalid_n = owner_q;
                    i_rvalid_n = ~owner_q;
                    d_err_n    = owner_q & expire;
                    i_err_n    = ~owner_q & expire;
                    if (complete) begin
                        if (owner_q) d_rdata_n = rd;
                        else         i_rdata_n = rd;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, priority, stores, timeout,
// async reset and a stalled memory handshake.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, d_ext, m_ack, m_rvalid;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [1:0]  d_width;
    logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
    logic        m_req, m_we, m_ext;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [1:0]  m_width;

    int checks = 0;
    int errors = 0;
    int overlap = 0;
    int cyc;
    int gcnt;
    logic pend = 1'b0;
    int order[$];

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_width(d_width), .d_ext(d_ext), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_width(m_width), .m_ext(m_ext), .m_ack(m_ack),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one cycle with a memory that acks at once and answers next cycle
    task automatic step();
        tick();
        if (i_gnt && d_gnt) overlap++;
        if (i_rvalid && d_rvalid) overlap++;
        if (d_gnt) order.push_back(0);
        if (i_gnt) order.push_back(1);
        m_rvalid = pend;
        m_rdata  = 32'h600D0000 + 32'(order.size());
        pend     = 1'b0;
        m_ack    = 1'b0;
        if (m_req) begin
            m_ack = 1'b1;
            pend  = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; d_ext = 0; m_ack = 0; m_rvalid = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0; d_width = 0;
        repeat (2) tick();
        chk("rst_m_req", m_req, 0);
        chk("rst_gnt", {i_gnt, d_gnt, i_rvalid, d_rvalid}, 0);
        #2 rst = 1'b0;

        // D load, minimum latency
        tick();
        d_req = 1; d_addr = 32'h10010008; d_width = 2'b10;
        tick();
        chk("t1_d_gnt", d_gnt, 1);
        chk("t1_i_gnt", i_gnt, 0);
        chk("t1_m_req", m_req, 1);
        chk("t1_m_addr", m_addr, 32'h10010008);
        chk("t1_m_we", m_we, 0);
        d_req = 0; m_ack = 1;
        tick();
        chk("t1_m_req_drop", m_req, 0);
        chk("t1_early_rv", d_rvalid, 0);
        m_ack = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
        tick();
        m_rvalid = 0;
        chk("t1_d_rvalid", d_rvalid, 1);
        chk("t1_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("t1_d_err", d_err, 0);
        chk("t1_i_rvalid", i_rvalid, 0);
        tick();
        chk("t1_rv_pulse", d_rvalid, 0);

        // both requesters held: starvation guard
        i_req = 1; i_addr = 32'h80; d_req = 1; d_addr = 32'h10010010;
        order.delete(); overlap = 0; cyc = 0;
        while (order.size() < 10 && cyc < 100) begin
            step();
            cyc++;
        end
        i_req = 0; d_req = 0;
        repeat (4) step();
        chk("t2_count", order.size(), 10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("t2_gnt%0d", k), order[k],
                (k == 4 || k == 9) ? 1 : 0);
        chk("t2_overlap", overlap, 0);

        // store with a two-cycle ack delay
        d_req = 1; d_we = 1; d_wdata = 32'h12345678; d_width = 2'b00;
        d_addr = 32'h2000;
        tick();
        chk("t3_gnt", d_gnt, 1);
        chk("t3_m_we", m_we, 1);
        chk("t3_m_wdata", m_wdata, 32'h12345678);
        chk("t3_m_width", m_width, 0);
        chk("t3_m_ext", m_ext, 0);
        d_req = 0; d_we = 0;
        tick();
        chk("t3_hold_req", m_req, 1);
        chk("t3_hold_wdata", m_wdata, 32'h12345678);
        m_ack = 1;
        tick();
        m_ack = 0; m_rvalid = 1; m_rdata = 32'hFFFFFFFF;
        tick();
        m_rvalid = 0;
        chk("t3_rvalid", d_rvalid, 1);
        chk("t3_rdata", d_rdata, 0);
        chk("t3_err", d_err, 0);

        // timeout with no ack
        i_req = 1; i_addr = 32'h100;
        tick();
        chk("t4_gnt", i_gnt, 1);
        i_req = 0;
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("t4_wait%0d", k), {m_req, i_rvalid}, 2'b10);
        end
        tick();
        chk("t4_m_req", m_req, 0);
        chk("t4_rvalid", i_rvalid, 1);
        chk("t4_err", i_err, 1);
        chk("t4_rdata", i_rdata, 0);

        // completion on the last timer cycle wins, later one is stale
        i_req = 1; i_addr = 32'h104;
        tick();
        chk("t4b_gnt", i_gnt, 1);
        i_req = 0; m_ack = 1;
        tick();
        m_ack = 0;
        repeat (6) tick();
        m_rvalid = 1; m_rdata = 32'hCAFEF00D;
        tick();
        chk("t4b_rvalid", i_rvalid, 1);
        chk("t4b_err", i_err, 0);
        chk("t4b_rdata", i_rdata, 32'hCAFEF00D);
        m_rdata = 32'hBAD;
        tick();
        m_rvalid = 0;
        chk("t4b_stale", {i_rvalid, d_rvalid, m_req}, 0);

        // async reset while in WAIT with streak saturated
        i_req = 1; d_req = 1; i_addr = 32'h200; d_addr = 32'h3000;
        d_we = 1; d_wdata = 32'h55AA55AA; d_width = 2'b10;
        order.delete(); cyc = 0;
        while (order.size() < 4 && cyc < 60) begin
            step();
            cyc++;
        end
        i_req = 0; d_req = 0; d_we = 0;
        chk("t5_count", order.size(), 4);
        chk("t5_last_d", order[3], 0);
        tick();
        m_ack = 0; m_rvalid = 0; pend = 0;
        chk("t5_in_wait", m_addr, 32'h3000);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_addr", m_addr, 0);
        chk("t5_rst_wdata", m_wdata, 0);
        chk("t5_rst_we", {m_we, m_req, d_gnt, d_rvalid}, 0);
        #2 rst = 1'b0;
        m_rvalid = 1;
        tick();
        m_rvalid = 0;
        chk("t5_no_rv1", {d_rvalid, i_rvalid}, 0);
        tick();
        chk("t5_no_rv2", {d_rvalid, i_rvalid}, 0);
        i_req = 1; d_req = 1;
        tick();
        chk("t5_d_wins", {i_gnt, d_gnt}, 2'b01);
        i_req = 0; d_req = 0;
        m_ack = 1; pend = 1;
        repeat (4) step();
        i_req = 1; i_addr = 32'h204;
        step();
        chk("t5_i_gnt", i_gnt, 1);
        i_req = 0;
        repeat (4) step();

        // ack held off for five cycles
        i_req = 1; i_addr = 32'h0000ABCC;
        gcnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (i_gnt || d_gnt) gcnt++;
            i_req = 0;
            chk($sformatf("t6_req%0d", k), m_req, 1);
            chk($sformatf("t6_addr%0d", k), m_addr, 32'h0000ABCC);
        end
        chk("t6_gnt_once", gcnt, 1);
        m_ack = 1;
        tick();
        m_ack = 0; m_rvalid = 1; m_rdata = 32'h0BADCAFE;
        chk("t6_ack_drop", m_req, 0);
        tick();
        m_rvalid = 0;
        chk("t6_rvalid", i_rvalid, 1);
        chk("t6_rdata", i_rdata, 32'h0BADCAFE);
        chk("t6_err", i_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
